display_encoder: RTL and testbench
==================================

# display_encoder

Downstream of the execution stage: takes the 17-bit running total and error flag it produces and drives a five-digit seven-segment display as one 35-bit segment word. Converts binary to BCD sequentially (shift-add-3, one bit per clock), blanks leading zeros, and shows "Err" on error or overrange. Sits between the execution stage's result/error outputs and the board's display pins; the displayed word only changes on a completed conversion.

## Interface
- DIGITS, 5, number of displayed digits; the layout below is fixed to 5
- BIN_W, 17, binary input width
- BLANK_LEADING, 1, 1 = blank leading zeros; 0 = show all zeros
- clk  in  1  single system clock, rising-edge
- reset  in  1  asynchronous, active-high; clears all state and outputs immediately
- value  in  17  unsigned binary total to display
- err  in  1  error flag from the execution stage
- load  in  1  conversion request, level-sampled each rising edge, accepted only in IDLE
- segments  out  35  digit k at bits [7k+6:7k], k=0 least significant; per digit bit order gfedcba, active-high
- busy  out  1  conversion in progress
- done  out  1  one-cycle pulse when segments update
- err_shown  out  1  segments currently show "Err"

## Operation
- States: IDLE, SHIFT, ENCODE.
- IDLE, load=1 at a rising edge:
  - capture value and err
  - clear the 20-bit BCD accumulator and 5-bit bit counter
  - go to SHIFT
- SHIFT, each cycle:
  - add 3 to every BCD nibble that is ≥5
  - shift {bcd, bin} left by one
  - after 17 shifts, go to ENCODE
- ENCODE: register segments, err_shown and done; go to IDLE.
- Error rule: captured err=1 or captured value>99999 selects "Err" = digits 4..0: blank, blank, E, r, r.
  - E=1111001, r=1010000, blank=0000000.
  - err_shown=1.
  - Conversion still runs the full SHIFT sequence, so latency is uniform.
- Digit codes, gfedcba:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
- Leading-zero blanking (BLANK_LEADING=1): blank every zero digit above the highest nonzero digit; digit 0 is always shown, so a total of 0 displays "0".
- Loads arriving while busy are ignored, not queued.
- value and err are sampled only at the accepting edge; later changes do not affect the conversion in flight.

## Timing
- Reset values: segments=0, busy=0, done=0, err_shown=0, state IDLE, internal registers 0.
- E0 is the edge that accepts load. Counting from E0:
  - E0: busy=1.
  - E1..E17: shifts; state goes to ENCODE after E17.
  - E18: segments and err_shown updated, done=1, busy=0, state IDLE.
  - E19: done=0.
- Latency: 18 clocks from accept to segment update.
- Back-to-back: with load held high, the next accept is at E19. Throughput is one conversion per 19 clocks.
- Reset mid-conversion: asynchronously forces reset values. No done pulse; the previous segments are lost (cleared to blank).
- A reset deassertion coinciding with load=1 is not accepted until the first rising edge after deassertion.
- Between conversions, segments and err_shown hold their values.

## Structure
- Package display_pkg holds:
  - the state enum
  - DIGITS and BIN_W defaults
  - MAX_DISPLAY=99999
  - the segment constants for 0-9, E, r and blank
- Sub-module seg7_decoder: combinational 4-bit BCD to 7-bit segments, 10-15 decoding to blank; instantiated DIGITS times.
- Blanking and "Err" selection live in display_encoder.

## Test plan
- Reset: assert reset mid-idle → segments=0, busy=0, done=0, err_shown=0 with no clock edge required.
- value=1250, load pulse → busy high E0..E17, at E18 segments = blank,1,2,5,0 (0x0 from digit 4 down: 0000000,0000110,1011011,1101101,0111111), done high exactly one cycle.
- value=99999 → all five digits 1101111. Then value=0 → four blanks plus 0111111. Then, with BLANK_LEADING=0, value=7 → 0,0,0,0,7.
- value=100000 → "Err", err_shown=1. Then err=1 with value=5 → "Err". Then err=0 with value=5 → err_shown=0, digit0=1101101.
- load held high for 40 cycles with value changing every cycle → accepts only at E0 and E19, each result matches the value captured at its accepting edge, and exactly two done pulses appear.
- Start a conversion of 1250 after displaying 42, assert reset at E10 → busy drops immediately, segments=0, and no done pulse follows.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment display encoder.
package display_pkg;

    // Conversion controller states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_ENCODE = 2'd2
    } state_e;

    localparam int DIGITS_DEF  = 5;
    localparam int BIN_W_DEF   = 17;
    localparam int MAX_DISPLAY = 99999;

    // Segment patterns, bit order gfedcba, active-high
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_E     = 7'b1111001;
    localparam logic [6:0] SEG_R     = 7'b1010000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD digit to seven-segment pattern; non-decimal codes go blank.
module seg7_decoder
    import display_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    // Table lookup of the digit pattern
    always_comb begin
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/display_encoder.sv
// Sequential binary-to-BCD (shift-add-3) converter driving a five-digit
// seven-segment display, with leading-zero blanking and an "Err" word.
// Handshake: load is a level request sampled on each rising edge and is
// only honoured while idle (busy=0); done pulses for one cycle in the
// cycle the segment word changes. There is no queueing of requests.
module display_encoder
    import display_pkg::*;
#(
    parameter int DIGITS        = DIGITS_DEF,
    parameter int BIN_W         = BIN_W_DEF,
    parameter int BLANK_LEADING = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BIN_W-1:0]      value,
    input  logic                  err,
    input  logic                  load,
    output logic [7*DIGITS-1:0]   segments,
    output logic                  busy,
    output logic                  done,
    output logic                  err_shown
);

    localparam int BCD_W = 4 * DIGITS;
    localparam logic [BIN_W-1:0] MAX_BIN    = BIN_W'(MAX_DISPLAY);
    localparam logic [4:0]       LAST_SHIFT = 5'(BIN_W - 1);

    state_e               state_q, state_d;
    logic [BIN_W-1:0]     bin_q, bin_d;
    logic [BCD_W-1:0]     bcd_q, bcd_d;
    logic [BCD_W-1:0]     bcd_adj;
    logic [4:0]           cnt_q, cnt_d;
    logic                 err_cap_q, err_cap_d;
    logic [7*DIGITS-1:0]  segments_q, segments_d;
    logic                 err_shown_q, err_shown_d;
    logic                 done_q, done_d;
    logic [7*DIGITS-1:0]  num_word, err_word;
    logic                 leading;
    logic [6:0]           dec_seg [DIGITS];

    // One decoder per digit, fed from the final BCD accumulator
    for (genvar g = 0; g < DIGITS; g++) begin : g_dec
        seg7_decoder u_dec (
            .bcd_i (bcd_q[4*g +: 4]),
            .seg_o (dec_seg[g])
        );
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic: accept in IDLE, 17 shifts, one encode cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (load) state_d = ST_SHIFT;
            ST_SHIFT:  if (cnt_q == LAST_SHIFT) state_d = ST_ENCODE;
            ST_ENCODE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state_q != ST_IDLE);
    end

    // Display words: numeric with leading-zero blanking, and the fixed "Err"
    always_comb begin
        num_word = '0;
        err_word = '0;
        leading  = (BLANK_LEADING != 0);
        for (int k = DIGITS - 1; k >= 0; k--) begin
            if (leading && (k != 0) && (bcd_q[4*k +: 4] == 4'd0)) begin
                num_word[7*k +: 7] = SEG_BLANK;
            end else begin
                num_word[7*k +: 7] = dec_seg[k];
                leading = 1'b0;
            end
            if (k == 2)      err_word[7*k +: 7] = SEG_E;
            else if (k < 2)  err_word[7*k +: 7] = SEG_R;
            else             err_word[7*k +: 7] = SEG_BLANK;
        end
    end

    // Datapath next state: capture, shift-add-3, and final encode
    always_comb begin
        bin_d       = bin_q;
        bcd_d       = bcd_q;
        cnt_d       = cnt_q;
        err_cap_d   = err_cap_q;
        segments_d  = segments_q;
        err_shown_d = err_shown_q;
        done_d      = 1'b0;
        bcd_adj     = bcd_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
        end
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    bin_d     = value;
                    err_cap_d = err | (value > MAX_BIN);
                    bcd_d     = '0;
                    cnt_d     = '0;
                end
            end
            ST_SHIFT: begin
                bcd_d = {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
                bin_d = {bin_q[BIN_W-2:0], 1'b0};
                cnt_d = cnt_q + 5'd1;
            end
            ST_ENCODE: begin
                segments_d  = err_cap_q ? err_word : num_word;
                err_shown_d = err_cap_q;
                done_d      = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bin_q       <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            err_cap_q   <= 1'b0;
            segments_q  <= '0;
            err_shown_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            err_cap_q   <= err_cap_d;
            segments_q  <= segments_d;
            err_shown_q <= err_shown_d;
            done_q      <= done_d;
        end
    end

    assign segments  = segments_q;
    assign err_shown = err_shown_q;
    assign done      = done_q;

endmodule

// File: tb/tb_display_encoder.sv
// Bench for display_encoder: one instance with leading-zero blanking, one without.
module tb_display_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [16:0] value;
  logic        err;
  logic        load;
  logic        load_nb;
  logic [34:0] segments, seg_nb;
  logic        busy, done, err_shown;
  logic        busy_nb, done_nb, errs_nb;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Scoreboard entries are {err_shown, segments}
  logic [35:0] exp_q[$];

  logic [6:0] seg_tab [0:9] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                                7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                                7'b1111111, 7'b1101111};
  localparam logic [6:0] T_E = 7'b1111001;
  localparam logic [6:0] T_R = 7'b1010000;

  display_encoder #(.DIGITS(5), .BIN_W(17), .BLANK_LEADING(1)) dut (
    .clk(clk), .reset(reset), .value(value), .err(err), .load(load),
    .segments(segments), .busy(busy), .done(done), .err_shown(err_shown)
  );

  display_encoder #(.DIGITS(5), .BIN_W(17), .BLANK_LEADING(0)) dut_nb (
    .clk(clk), .reset(reset), .value(value), .err(err), .load(load_nb),
    .segments(seg_nb), .busy(busy_nb), .done(done_nb), .err_shown(errs_nb)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [35:0] model(input int v, input bit e, input bit blank);
    logic [35:0] w;
    int d [5];
    int tmp;
    bit lead;
    w = '0;
    if (e || v > 99999) begin
      w = {1'b1, 7'b0, 7'b0, T_E, T_R, T_R};
    end else begin
      tmp = v;
      for (int k = 0; k < 5; k++) begin
        d[k] = tmp % 10;
        tmp  = tmp / 10;
      end
      lead = blank;
      for (int k = 4; k >= 0; k--) begin
        if (lead && k != 0 && d[k] == 0) w[7*k +: 7] = 7'b0;
        else begin
          w[7*k +: 7] = seg_tab[d[k]];
          lead = 1'b0;
        end
      end
    end
    return w;
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic start_conv(input int v, input bit e, input bit sel, input bit push);
    value = 17'(v);
    err   = e;
    if (sel) load_nb = 1'b1; else load = 1'b1;
    if (push) exp_q.push_back(model(v, e, !sel));
    @(posedge clk);
    @(negedge clk);
    load    = 1'b0;
    load_nb = 1'b0;
  endtask

  task automatic wait_done(input bit sel, output int lat, output int busy_cnt, output bit timeout);
    lat = 0; busy_cnt = 0; timeout = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (sel ? done_nb : done) begin
        timeout = 1'b0;
        break;
      end
      if (sel ? busy_nb : busy) busy_cnt++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b1; load = 1'b0; load_nb = 1'b0; value = '0; err = 1'b0;
    repeat (3) @(negedge clk);
    vec_cnt++;
    if ({segments, busy, done, err_shown} !== 38'd0) begin
      err_cnt++;
      $display("FAIL reset_state: got seg=%h busy=%b done=%b errs=%b, want all 0",
               segments, busy, done, err_shown);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_one(input string name, input int v, input bit e, input bit sel);
    int lat, bc; bit to;
    logic [35:0] exp_w, got;
    start_conv(v, e, sel, 1'b1);
    wait_done(sel, lat, bc, to);
    vec_cnt++;
    if (to) begin
      err_cnt++;
      $display("FAIL %s_timeout: no done within 40 cycles", name);
      void'(exp_q.pop_front());
    end else begin
      got   = sel ? {errs_nb, seg_nb} : {err_shown, segments};
      exp_w = exp_q.pop_front();
      if (got !== exp_w) begin
        err_cnt++;
        $display("FAIL %s: got %h, want %h", name, got, exp_w);
      end
    end
  endtask

  task automatic test_basic;
    int lat, bc; bit to;
    logic [35:0] exp_w;
    start_conv(1250, 1'b0, 1'b0, 1'b1);
    vec_cnt++;
    if (busy !== 1'b1) begin err_cnt++; $display("FAIL busy_e0: got %b, want 1", busy); end
    wait_done(1'b0, lat, bc, to);
    vec_cnt++;
    if (to || lat != 18) begin
      err_cnt++; $display("FAIL latency: got %0d (timeout=%b), want 18", lat, to);
    end
    vec_cnt++;
    if (bc != 17) begin err_cnt++; $display("FAIL busy_span: got %0d, want 17", bc); end
    vec_cnt++;
    if (busy !== 1'b0) begin err_cnt++; $display("FAIL busy_e18: got %b, want 0", busy); end
    exp_w = exp_q.pop_front();
    vec_cnt++;
    if ({err_shown, segments} !== exp_w ||
        segments !== {7'b0000000, 7'b0000110, 7'b1011011, 7'b1101101, 7'b0111111}) begin
      err_cnt++; $display("FAIL seg_1250: got %h, want %h", {err_shown, segments}, exp_w);
    end
    @(negedge clk);
    vec_cnt++;
    if (done !== 1'b0) begin err_cnt++; $display("FAIL done_width: got %b at E19, want 0", done); end
    vec_cnt++;
    if (segments !== exp_w[34:0]) begin
      err_cnt++; $display("FAIL seg_hold: got %h, want %h", segments, exp_w[34:0]);
    end
  endtask

  task automatic test_digits;
    run_one("seg_99999", 99999, 1'b0, 1'b0);
    vec_cnt++;
    if (segments !== {5{7'b1101111}}) begin
      err_cnt++; $display("FAIL all_nines: got %h, want %h", segments, {5{7'b1101111}});
    end
    run_one("seg_zero", 0, 1'b0, 1'b0);
    run_one("seg_nb_7", 7, 1'b0, 1'b1);
    run_one("seg_nb_40302", 40302, 1'b0, 1'b1);
    run_one("seg_10005", 10005, 1'b0, 1'b0);
    run_one("seg_600", 600, 1'b0, 1'b0);
  endtask

  task automatic test_error;
    run_one("err_100000", 100000, 1'b0, 1'b0);
    vec_cnt++;
    if (err_shown !== 1'b1) begin err_cnt++; $display("FAIL err_shown_ovr: got %b, want 1", err_shown); end
    run_one("err_max", 131071, 1'b0, 1'b0);
    run_one("err_flag", 5, 1'b1, 1'b0);
    run_one("err_clear", 5, 1'b0, 1'b0);
    vec_cnt++;
    if (err_shown !== 1'b0 || segments[6:0] !== 7'b1101101) begin
      err_cnt++; $display("FAIL err_clear_d0: got errs=%b d0=%b, want 0/1101101", err_shown, segments[6:0]);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 8; i++) begin
      run_one("rand", $urandom_range(0, 131071), ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_back_to_back;
    int dcnt = 0;
    int lat, bc; bit to;
    logic [35:0] exp_w;
    load = 1'b1;
    for (int c = 0; c < 40; c++) begin
      value = 17'($urandom_range(0, 99999));
      err   = 1'b0;
      if (c % 19 == 0) exp_q.push_back(model(int'(value), 1'b0, 1'b1));
      @(posedge clk);
      @(negedge clk);
      vec_cnt++;
      if (done !== (c % 19 == 18)) begin
        err_cnt++; $display("FAIL b2b_done_edge%0d: got %b, want %b", c, done, (c % 19 == 18));
      end
      if (done === 1'b1) begin
        dcnt++;
        exp_w = exp_q.pop_front();
        vec_cnt++;
        if ({err_shown, segments} !== exp_w) begin
          err_cnt++; $display("FAIL b2b_result: got %h, want %h", {err_shown, segments}, exp_w);
        end
      end
    end
    load = 1'b0;
    vec_cnt++;
    if (dcnt != 2) begin err_cnt++; $display("FAIL b2b_pulses: got %0d, want 2", dcnt); end
    wait_done(1'b0, lat, bc, to);
    vec_cnt++;
    if (to) begin
      err_cnt++; $display("FAIL b2b_third_timeout: got none, want done");
      void'(exp_q.pop_front());
    end else begin
      exp_w = exp_q.pop_front();
      if ({err_shown, segments} !== exp_w) begin
        err_cnt++; $display("FAIL b2b_third: got %h, want %h", {err_shown, segments}, exp_w);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int dcnt = 0;
    run_one("pre_42", 42, 1'b0, 1'b0);
    // idle reset: must clear without any clock edge
    #2 reset = 1'b1;
    #1;
    vec_cnt++;
    if ({segments, busy, done, err_shown} !== 38'd0) begin
      err_cnt++; $display("FAIL reset_idle: got seg=%h busy=%b done=%b errs=%b, want 0",
                          segments, busy, done, err_shown);
    end
    reset = 1'b0;
    @(negedge clk);
    run_one("pre_42b", 42, 1'b0, 1'b0);
    start_conv(1250, 1'b0, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    vec_cnt++;
    if (busy !== 1'b0 || segments !== 35'd0 || done !== 1'b0 || err_shown !== 1'b0) begin
      err_cnt++; $display("FAIL reset_mid: got busy=%b seg=%h done=%b, want 0/0/0", busy, segments, done);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done === 1'b1) dcnt++;
    end
    vec_cnt++;
    if (dcnt != 0 || segments !== 35'd0) begin
      err_cnt++; $display("FAIL reset_no_done: got %0d pulses seg=%h, want 0/0", dcnt, segments);
    end
    vec_cnt++;
    if (exp_q.size() != 0) begin
      err_cnt++; $display("FAIL scoreboard_left: got %0d entries, want 0", exp_q.size());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_digits();
    test_error();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
